cordic_rotation_engine: RTL and testbench

- Iterative, one-micro-rotation-per-clock CORDIC core in rotation mode. Drives z toward zero.
- Supports circular, linear and hyperbolic coordinate systems.
- Sits directly upstream of the gain-compensation Scaler: x_out and y_out carry the raw CORDIC gain, which the Scaler removes using the same mode code.
- Start/ready/done handshake; one operation in flight.

---
 rtl/cordic_rotation_engine_pkg.sv | 20 ++
 rtl/cordic_rotation_engine_if.sv | 28 ++
 rtl/cordic_rotation_engine_angle_rom.sv | 54 +++++
 rtl/cordic_rotation_engine.sv | 134 +++++++++++++
 tb/tb_cordic_rotation_engine.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_rotation_engine_pkg.sv
// Shared constants for the CORDIC rotation engine: mode codes, FSM states and
// the Q3.28 unit value.
package cordic_rotation_engine_pkg;

  typedef enum logic [1:0] {
    CIRCULAR   = 2'd0,
    LINEAR     = 2'd1,
    HYPERBOLIC = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] ONE   = 32'h1000_0000;
  localparam int          IDX_W = 5;

endpackage

// File: rtl/cordic_rotation_engine_if.sv
// Start/ready/done handshake and operand/result bundle of the CORDIC engine.
interface cordic_rotation_engine_if #(
  parameter int WIDTH = 32
) ();

  logic                    start;
  logic [1:0]              mode;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic signed [WIDTH-1:0] z_in;
  logic                    ready;
  logic                    done;
  logic signed [WIDTH-1:0] x_out;
  logic signed [WIDTH-1:0] y_out;
  logic signed [WIDTH-1:0] z_out;
  logic [1:0]              mode_out;

  modport master (
    output start, mode, x_in, y_in, z_in,
    input  ready, done, x_out, y_out, z_out, mode_out
  );

  modport slave (
    input  start, mode, x_in, y_in, z_in,
    output ready, done, x_out, y_out, z_out, mode_out
  );

endinterface

// File: rtl/cordic_rotation_engine_angle_rom.sv
// Combinational elementary-angle table in Q3.28: atan(2^-i), atanh(2^-i) or
// 2^-i selected by the coordinate-system code, rounded to nearest.
module cordic_angle_rom
  import cordic_rotation_engine_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]              mode_i,
  input  logic [IDX_W-1:0]        idx_i,
  output logic signed [WIDTH-1:0] angle_o
);

  // Beyond i = 9 both atan and atanh round to 2^-i at 28 fractional bits.
  function automatic logic [31:0] atan_q28(input logic [IDX_W-1:0] i);
    case (i)
      5'd0:    return 32'd210828714;
      5'd1:    return 32'd124459457;
      5'd2:    return 32'd65760959;
      5'd3:    return 32'd33381290;
      5'd4:    return 32'd16755422;
      5'd5:    return 32'd8385879;
      5'd6:    return 32'd4193963;
      5'd7:    return 32'd2097109;
      5'd8:    return 32'd1048571;
      5'd9:    return 32'd524287;
      default: return ONE >> i;
    endcase
  endfunction

  function automatic logic [31:0] atanh_q28(input logic [IDX_W-1:0] i);
    case (i)
      5'd0:    return 32'd0;
      5'd1:    return 32'd147453245;
      5'd2:    return 32'd68561855;
      5'd3:    return 32'd33730852;
      5'd4:    return 32'd16799113;
      5'd5:    return 32'd8391340;
      5'd6:    return 32'd4194645;
      5'd7:    return 32'd2097195;
      5'd8:    return 32'd1048581;
      5'd9:    return 32'd524289;
      default: return ONE >> i;
    endcase
  endfunction

  always_comb begin
    case (mode_i)
      HYPERBOLIC: angle_o = $signed(WIDTH'(atanh_q28(idx_i)));
      LINEAR:     angle_o = $signed(WIDTH'(ONE >> idx_i));
      default:    angle_o = $signed(WIDTH'(atan_q28(idx_i)));
    endcase
  end

endmodule

// File: rtl/cordic_rotation_engine.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock in circular,
// linear or hyperbolic coordinates; results leave unscaled with their mode.
module cordic_rotation_engine
  import cordic_rotation_engine_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ITERATIONS = 16
) (
  input logic                    clk,
  input logic                    reset,
  cordic_rotation_engine_if.slave bus
);

  state_e                  state_q, state_d;
  logic [1:0]              mode_q, mode_d, mode_out_q, mode_out_d;
  logic [IDX_W-1:0]        idx_q, idx_d, last_idx;
  logic                    rep_q, rep_d, rep_needed, last_step, d_pos;
  logic signed [WIDTH-1:0] x_q, y_q, z_q, x_d, y_d, z_d;
  logic signed [WIDTH-1:0] x_out_q, y_out_q, z_out_q, x_out_d, y_out_d, z_out_d;
  logic signed [WIDTH-1:0] ang, x_sh, y_sh, x_rot, y_rot, z_rot;

  cordic_angle_rom #(.WIDTH(WIDTH)) u_rom (
    .mode_i (mode_q),
    .idx_i  (idx_q),
    .angle_o(ang)
  );

  assign x_sh  = x_q >>> idx_q;
  assign y_sh  = y_q >>> idx_q;
  assign d_pos = ~z_q[WIDTH-1];

  always_comb begin
    x_rot = x_q;
    y_rot = y_q;
    z_rot = z_q;
    case (mode_q)
      CIRCULAR, LINEAR, HYPERBOLIC: begin
        y_rot = d_pos ? y_q + x_sh : y_q - x_sh;
        z_rot = d_pos ? z_q - ang  : z_q + ang;
      end
      default: ;
    endcase
    if (mode_q == CIRCULAR)   x_rot = d_pos ? x_q - y_sh : x_q + y_sh;
    if (mode_q == HYPERBOLIC) x_rot = d_pos ? x_q + y_sh : x_q - y_sh;
  end

  // Hyperbolic convergence needs indices 4 and 13 run twice; rep_q marks the second pass.
  assign rep_needed = (mode_q == HYPERBOLIC) && !rep_q && (idx_q == 5'd4 || idx_q == 5'd13);
  assign last_idx   = (mode_q == HYPERBOLIC) ? IDX_W'(ITERATIONS) : IDX_W'(ITERATIONS - 1);
  assign last_step  = (idx_q == last_idx) && !rep_needed;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    rep_d      = rep_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    x_out_d    = x_out_q;
    y_out_d    = y_out_q;
    z_out_d    = z_out_q;
    mode_out_d = mode_out_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = RUN;
          mode_d  = bus.mode;
          idx_d   = (bus.mode == HYPERBOLIC) ? IDX_W'(1) : '0;
          rep_d   = 1'b0;
          x_d     = bus.x_in;
          y_d     = bus.y_in;
          z_d     = bus.z_in;
        end
      end
      RUN: begin
        x_d = x_rot;
        y_d = y_rot;
        z_d = z_rot;
        if (rep_needed) begin
          rep_d = 1'b1;
        end else begin
          rep_d = 1'b0;
          idx_d = idx_q + 5'd1;
        end
        if (last_step) begin
          state_d    = DONE;
          x_out_d    = x_rot;
          y_out_d    = y_rot;
          z_out_d    = z_rot;
          mode_out_d = mode_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= CIRCULAR;
      idx_q      <= '0;
      rep_q      <= 1'b0;
      x_out_q    <= '0;
      y_out_q    <= '0;
      z_out_q    <= '0;
      mode_out_q <= LINEAR;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      rep_q      <= rep_d;
      x_out_q    <= x_out_d;
      y_out_q    <= y_out_d;
      z_out_q    <= z_out_d;
      mode_out_q <= mode_out_d;
    end
  end

  always_ff @(posedge clk) begin
    x_q <= x_d;
    y_q <= y_d;
    z_q <= z_d;
  end

  assign bus.ready    = (state_q != RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.x_out    = x_out_q;
  assign bus.y_out    = y_out_q;
  assign bus.z_out    = z_out_q;
  assign bus.mode_out = mode_out_q;

endmodule

// File: tb/tb_cordic_rotation_engine.sv
// Randomized bench for cordic_rotation_engine against an algorithmic CORDIC
// model built from real-valued angle tables, plus ideal-math sanity checks.
module tb_cordic_rotation_engine;
  import cordic_rotation_engine_pkg::*;

  localparam int  WIDTH      = 32;
  localparam int  ITERATIONS = 16;
  localparam real SCALE      = 268435456.0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cordic_rotation_engine_if #(.WIDTH(WIDTH)) bus ();

  cordic_rotation_engine #(.WIDTH(WIDTH), .ITERATIONS(ITERATIONS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint obs, input longint exp, input longint tol = 0);
    longint diff;
    n_checks++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h) tol %0d", tag, obs, obs, exp, exp, tol);
    end
  endtask

  function automatic longint wrap32(input longint v);
    logic signed [31:0] t;
    t = v[31:0];
    return longint'(t);
  endfunction

  function automatic longint ref_angle(input int m, input int i);
    real x, a;
    x = 1.0 / (2.0 ** i);
    if (m == int'(CIRCULAR))        a = $atan(x);
    else if (m == int'(HYPERBOLIC)) a = (i == 0) ? 0.0 : 0.5 * $ln((1.0 + x) / (1.0 - x));
    else                            a = x;
    return longint'($floor(a * SCALE + 0.5));
  endfunction

  function automatic longint to_q(input real v);
    return longint'($floor(v * SCALE + 0.5));
  endfunction

  // Run the whole CORDIC recurrence over the index schedule; also return the step count and gain.
  function automatic void model_op(input int m, input longint x0, input longint y0, input longint z0,
                                   output longint xo, output longint yo, output longint zo,
                                   output int n, output real k);
    int     sched[$];
    longint x, y, z, xs, ys, xn, sgn;
    x = x0; y = y0; z = z0; k = 1.0;
    if (m == int'(HYPERBOLIC)) begin
      for (int i = 1; i <= ITERATIONS; i++) begin
        sched.push_back(i);
        if (i == 4 || i == 13) sched.push_back(i);
      end
    end else begin
      for (int i = 0; i < ITERATIONS; i++) sched.push_back(i);
    end
    foreach (sched[j]) begin
      int i;
      i = sched[j];
      if (m != 3) begin
        sgn = (z >= 0) ? 1 : -1;
        xs  = x >>> i;
        ys  = y >>> i;
        if (m == int'(CIRCULAR)) begin
          xn = x - sgn * ys;
          k  = k * $sqrt(1.0 + 2.0 ** (-2 * i));
        end else if (m == int'(HYPERBOLIC)) begin
          xn = x + sgn * ys;
          k  = k * $sqrt(1.0 - 2.0 ** (-2 * i));
        end else begin
          xn = x;
        end
        y = wrap32(y + sgn * xs);
        z = wrap32(z - sgn * ref_angle(m, i));
        x = wrap32(xn);
      end
    end
    xo = x; yo = y; zo = z; n = sched.size();
  endfunction

  // Called at a negedge with the engine ready; returns at a negedge (DONE if chain, else IDLE).
  task automatic do_op(input int m, input longint x0, input longint y0, input longint z0,
                       input bit chain, input bit noise,
                       output longint xo, output longint yo, output longint zo, output real k);
    longint ex, ey, ez, px;
    int     n, edges, c4, c13;
    bit     got;
    model_op(m, x0, y0, z0, ex, ey, ez, n, k);
    check("ready_before_start", longint'(bus.ready), 1);
    px         = longint'(bus.x_out);
    bus.mode   = 2'(m);
    bus.x_in   = WIDTH'(x0);
    bus.y_in   = WIDTH'(y0);
    bus.z_in   = WIDTH'(z0);
    bus.start  = 1'b1;
    @(posedge clk);
    edges = 1; c4 = 0; c13 = 0; got = 1'b0;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (dut.idx_q == 5'd4)  c4++;
      if (dut.idx_q == 5'd13) c13++;
      if (edges == 8) check("out_hold_during_run", longint'(bus.x_out), px);
      bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      edges++;
    end
    bus.start = 1'b0;
    check("done_seen", longint'(got), 1);
    if (!got) return;
    check("latency_edges", edges, n + 1);
    check("x_out", longint'(bus.x_out), ex);
    check("y_out", longint'(bus.y_out), ey);
    check("z_out", longint'(bus.z_out), ez);
    check("mode_out", longint'(bus.mode_out), m);
    if (m == int'(HYPERBOLIC)) begin
      check("repeat_idx4", c4, 2);
      check("repeat_idx13", c13, 2);
    end
    xo = longint'(bus.x_out);
    yo = longint'(bus.y_out);
    zo = longint'(bus.z_out);
    if (!chain) begin
      @(negedge clk);
      check("done_one_cycle", longint'(bus.done), 0);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, longint'(bus.ready), 1);
    check({tag, "_done"}, longint'(bus.done), 0);
    check({tag, "_x"}, longint'(bus.x_out), 0);
    check({tag, "_y"}, longint'(bus.y_out), 0);
    check({tag, "_z"}, longint'(bus.z_out), 0);
    check({tag, "_mode"}, longint'(bus.mode_out), int'(LINEAR));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint xo, yo, zo, rx, ry, rz;
    real    k, zr, xr, yr;
    int     m;
    bit     seen;

    reset = 1'b1;
    bus.start = 1'b0; bus.mode = 2'd0;
    bus.x_in = '0; bus.y_in = '0; bus.z_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);

    // Circular pi/4 from (1, 0)
    do_op(int'(CIRCULAR), 64'sh1000_0000, 0, 64'sh0C90_FDAA, 1'b0, 1'b0, xo, yo, zo, k);
    check("circ_x_ideal", xo, to_q(k * $cos(0.25 * 3.14159265358979)), 32768);
    check("circ_y_ideal", yo, to_q(k * $sin(0.25 * 3.14159265358979)), 32768);
    check("circ_z_resid", zo, 0, 16384);

    // Linear 2.0 * 1.5
    do_op(int'(LINEAR), 64'sh2000_0000, 0, 64'sh1800_0000, 1'b0, 1'b0, xo, yo, zo, k);
    check("lin_x_exact", xo, 64'sh2000_0000);
    check("lin_y_ideal", yo, 64'sh3000_0000, 32768);

    // Hyperbolic 0.5 from (1, 0)
    do_op(int'(HYPERBOLIC), 64'sh1000_0000, 0, 64'sh0800_0000, 1'b0, 1'b0, xo, yo, zo, k);
    check("hyp_x_ideal", xo, to_q(k * 0.5 * ($exp(0.5) + $exp(-0.5))), 32768);
    check("hyp_y_ideal", yo, to_q(k * 0.5 * ($exp(0.5) - $exp(-0.5))), 32768);

    // Fourth mode code passes operands through
    do_op(3, 64'h1234, 64'h5678, 64'h9ABC, 1'b0, 1'b0, xo, yo, zo, k);
    check("inv_x_pass", xo, 64'h1234);
    check("inv_y_pass", yo, 64'h5678);
    check("inv_z_pass", zo, 64'h9ABC);

    // Back-to-back: second start accepted in the DONE cycle, noise on start during RUN
    do_op(int'(CIRCULAR), 64'sh0800_0000, 64'sh0400_0000, -64'sh0600_0000, 1'b1, 1'b1, xo, yo, zo, k);
    do_op(int'(HYPERBOLIC), 64'sh0C00_0000, -64'sh0200_0000, 64'sh0A00_0000, 1'b0, 1'b1, xo, yo, zo, k);

    // Reset in the middle of an operation
    bus.mode = 2'(CIRCULAR); bus.x_in = 32'h1000_0000; bus.y_in = '0; bus.z_in = 32'h0800_0000;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("midrun_reset");
    reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("no_done_after_reset", longint'(seen), 0);
    do_op(int'(CIRCULAR), 64'sh1000_0000, 0, 64'sh0800_0000, 1'b0, 1'b0, xo, yo, zo, k);
    zr = real'(64'sh0800_0000) / SCALE;
    check("post_reset_x_ideal", xo, to_q(k * $cos(zr)), 32768);
    check("post_reset_y_ideal", yo, to_q(k * $sin(zr)), 32768);

    // Randomized operations inside each mode's convergence domain
    for (int t = 0; t < 24; t++) begin
      m  = $urandom_range(0, 3);
      rx = longint'($urandom_range(0, 32'h2000_0000)) - 64'sh1000_0000;
      ry = longint'($urandom_range(0, 32'h2000_0000)) - 64'sh1000_0000;
      case (m)
        0:       rz = longint'($urandom_range(0, 32'h3600_0000)) - 64'sh1B00_0000;
        1:       rz = longint'($urandom_range(0, 32'h3C00_0000)) - 64'sh1E00_0000;
        2:       begin
                   rz = longint'($urandom_range(0, 32'h2380_0000)) - 64'sh11C0_0000;
                   rx = rx + 64'sh1000_0000;
                   ry = ry >>> 2;
                 end
        default: rz = longint'($urandom_range(0, 32'h7FFF_FFFF)) - 64'sh4000_0000;
      endcase
      do_op(m, rx, ry, rz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), xo, yo, zo, k);
      if (m == 0) begin
        zr = real'(rz) / SCALE;
        xr = real'(rx) / SCALE;
        yr = real'(ry) / SCALE;
        check("rand_circ_x_ideal", xo, to_q(k * (xr * $cos(zr) - yr * $sin(zr))), 65536);
      end
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
